// File: rtl/otf_conversion_controller_pkg.sv
// ----------------------------------------------------------------------------
// otf_pkg
// Shared types and sizing helpers for the on-the-fly conversion controller.
//   state_t        : controller FSM states
//   digitBits()    : width of the magnitude field of one digit (d)
//   radixOf()      : radix r = 2**d
//   resultWidth()  : width W of the two's-complement result
//   digitCntWidth(): width of the accepted-digit counter
//   delayCntWidth(): width of the online-delay counter (never below 1 bit)
// ----------------------------------------------------------------------------
package otf_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      COLLECT = 2'd2,
      DONE    = 2'd3
   } state_t;

   localparam int DEFAULT_NO_OF_DIGITS = 4;
   localparam int DEFAULT_RADIX_BITS   = 3;
   localparam int DEFAULT_ONLINE_DELAY = 2;

   function automatic int digitBits(input int radixBits);
      return radixBits - 1;
   endfunction

   function automatic int radixOf(input int radixBits);
      return 1 << (radixBits - 1);
   endfunction

   function automatic int resultWidth(input int noOfDigits, input int radixBits);
      return noOfDigits * (radixBits - 1) + 1;
   endfunction

   // A zero-sized counter is not legal, so the minimum is clamped to 1 bit.
   function automatic int digitCntWidth(input int noOfDigits);
      return (noOfDigits < 1) ? 1 : $clog2(noOfDigits + 1);
   endfunction

   function automatic int delayCntWidth(input int onlineDelay);
      return (onlineDelay < 1) ? 1 : $clog2(onlineDelay + 1);
   endfunction

endpackage

// File: rtl/otf_conversion_controller_if.sv
// ----------------------------------------------------------------------------
// otf_conversion_controller_if
// Handshake bundle between a digit producer / result consumer (master) and the
// conversion controller (slave).
//   start      : begin a conversion (master -> slave)
//   busy       : controller not idle (slave -> master)
//   in_valid   : in_digit valid (master -> slave)
//   in_ready   : controller accepts digits (slave -> master)
//   in_digit   : signed digit, MSD first (master -> slave)
//   out_valid  : result valid (slave -> master)
//   out_ready  : consumer takes the result (master -> slave)
//   out_value  : signed W-bit result (slave -> master)
//   err        : illegal digit seen (slave -> master)
// ----------------------------------------------------------------------------
interface otf_conversion_controller_if #(
   parameter int NO_OF_DIGITS = 4,
   parameter int RADIX_BITS   = 3
) ();
   import otf_pkg::*;

   localparam int W = resultWidth(NO_OF_DIGITS, RADIX_BITS);

   logic                  start;
   logic                  busy;
   logic                  in_valid;
   logic                  in_ready;
   logic [RADIX_BITS-1:0] in_digit;
   logic                  out_valid;
   logic                  out_ready;
   logic [W-1:0]          out_value;
   logic                  err;

   modport master (
      output start,
      output in_valid,
      output in_digit,
      output out_ready,
      input  busy,
      input  in_ready,
      input  out_valid,
      input  out_value,
      input  err
   );

   modport slave (
      input  start,
      input  in_valid,
      input  in_digit,
      input  out_ready,
      output busy,
      output in_ready,
      output out_valid,
      output out_value,
      output err
   );

endinterface

// File: rtl/otf_conversion_controller_qqm_reg.sv
// ----------------------------------------------------------------------------
// otf_qqm_reg
// Q / QM register pair for on-the-fly conversion of a signed-digit stream.
// Each accepted digit shifts one digit field into both registers; the source
// register (Q or QM) is chosen by the digit's sign, so no W-bit adder exists.
// QM tracks Q-1 so that a negative digit can borrow without carry propagation.
//   clk    : rising-edge clock
//   reset  : synchronous active-high, Q=0 / QM=-1
//   clear  : synchronous restart for a new conversion, same values as reset
//   load   : shift in 'digit' this cycle
//   digit  : RADIX_BITS-wide two's-complement digit
//   q      : current converted value Q
// ----------------------------------------------------------------------------
module otf_qqm_reg #(
   parameter int RADIX_BITS = 3,
   parameter int W          = 9
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clear,
   input  logic                  load,
   input  logic [RADIX_BITS-1:0] digit,
   output logic [W-1:0]          q
);
   import otf_pkg::*;

   localparam int D = digitBits(RADIX_BITS);

   logic [W-1:0] r_q;
   logic [W-1:0] r_qm;

   logic         w_isNeg;
   logic         w_isPos;
   logic [D-1:0] w_field;
   logic [D-1:0] w_fieldM1;
   logic [W-1:0] w_qSrc;
   logic [W-1:0] w_qmSrc;
   logic [W-1:0] w_qNext;
   logic [W-1:0] w_qmNext;

   // The appended field for Q is q mod r (equals q for q>=0 and r+q for q<0);
   // for QM it is (q-1) mod r (q-1 for q>0, r-1+q for q<=0). Both are the low
   // d bits of a small d-bit quantity, so only the source selection differs.
   assign w_isNeg   = digit[RADIX_BITS-1];
   assign w_field   = digit[D-1:0];
   assign w_isPos   = !w_isNeg && (w_field != '0);
   assign w_fieldM1 = w_field - D'(1);

   assign w_qSrc    = w_isNeg ? r_qm : r_q;
   assign w_qmSrc   = w_isPos ? r_q  : r_qm;
   assign w_qNext   = (w_qSrc  << D) | W'(w_field);
   assign w_qmNext  = (w_qmSrc << D) | W'(w_fieldM1);

   // Register pair: restart on reset or clear, shift-and-select on load.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         r_q  <= '0;
         r_qm <= '1;
      end else if (load) begin
         r_q  <= w_qNext;
         r_qm <= w_qmNext;
      end
   end

   assign q = r_q;

endmodule

// File: rtl/otf_conversion_controller.sv
// ----------------------------------------------------------------------------
// otf_conversion_controller
// Sequences one online-arithmetic result conversion: after start it waits out
// the producer's online delay, accepts NO_OF_DIGITS signed digits MSD-first,
// converts them on the fly into a two's-complement integer and holds that
// result on the output handshake until the consumer takes it.
// Optional feature macro: OTF_DIGIT_CHECK_EN (flags digit -r, converts it as 0).
//   clk    : rising-edge clock
//   reset  : synchronous active-high, aborts any conversion
//   bus    : otf_conversion_controller_if.slave
//            start/busy, in_valid/in_ready/in_digit,
//            out_valid/out_ready/out_value, err
// ----------------------------------------------------------------------------
module otf_conversion_controller #(
   parameter int NO_OF_DIGITS = 4,
   parameter int RADIX_BITS   = 3,
   parameter int ONLINE_DELAY = 2
) (
   input logic                         clk,
   input logic                         reset,
   otf_conversion_controller_if.slave  bus
);
   import otf_pkg::*;

   localparam int W   = resultWidth(NO_OF_DIGITS, RADIX_BITS);
   localparam int DCW = digitCntWidth(NO_OF_DIGITS);
   localparam int WCW = delayCntWidth(ONLINE_DELAY);

   localparam logic [DCW-1:0] LAST_DIGIT = DCW'(NO_OF_DIGITS - 1);
   localparam logic [WCW-1:0] LAST_WAIT  = WCW'((ONLINE_DELAY > 0) ? ONLINE_DELAY - 1 : 0);

   state_t                r_state;
   logic                  r_busy;
   logic                  r_inReady;
   logic                  r_outValid;
   logic [DCW-1:0]        r_digitCnt;
   logic [WCW-1:0]        r_delayCnt;

   logic                  w_start;
   logic                  w_accept;
   logic [RADIX_BITS-1:0] w_loadDigit;
   logic [W-1:0]          w_q;

   // A start only counts while idle; it also restarts the Q/QM pair.
   // in_ready is only ever high in COLLECT, so accept needs no state decode.
   assign w_start  = (r_state == IDLE) && bus.start;
   assign w_accept = r_inReady && bus.in_valid;

`ifdef OTF_DIGIT_CHECK_EN
   logic w_illegal;
   logic r_err;

   // Digit -r is the lone pattern 1 followed by zeros; it falls outside the
   // redundant digit set and is replaced by 0 before conversion.
   assign w_illegal   = bus.in_digit[RADIX_BITS-1] && (bus.in_digit[RADIX_BITS-2:0] == '0);
   assign w_loadDigit = w_illegal ? '0 : bus.in_digit;

   // Sticky illegal-digit flag, cleared only by reset or an accepted start.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_err <= 1'b0;
      end else if (w_start) begin
         r_err <= 1'b0;
      end else if (w_accept && w_illegal) begin
         r_err <= 1'b1;
      end
   end

   assign bus.err = r_err;
`else
   assign w_loadDigit = bus.in_digit;
   assign bus.err     = 1'b0;
`endif

   // Controller FSM with its counters and registered handshake outputs.
   // Outputs are set together with the state they belong to, so busy,
   // in_ready and out_valid always agree with r_state.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_busy     <= 1'b0;
         r_inReady  <= 1'b0;
         r_outValid <= 1'b0;
         r_digitCnt <= '0;
         r_delayCnt <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_busy     <= 1'b1;
                  r_digitCnt <= '0;
                  r_delayCnt <= '0;
                  if (ONLINE_DELAY == 0) begin
                     r_state   <= COLLECT;
                     r_inReady <= 1'b1;
                  end else begin
                     r_state   <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (r_delayCnt == LAST_WAIT) begin
                  r_state   <= COLLECT;
                  r_inReady <= 1'b1;
               end else begin
                  r_delayCnt <= r_delayCnt + WCW'(1);
               end
            end
            COLLECT: begin
               if (w_accept) begin
                  r_digitCnt <= r_digitCnt + DCW'(1);
                  if (r_digitCnt == LAST_DIGIT) begin
                     r_state    <= DONE;
                     r_inReady  <= 1'b0;
                     r_outValid <= 1'b1;
                  end
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  r_state    <= IDLE;
                  r_busy     <= 1'b0;
                  r_outValid <= 1'b0;
               end
            end
            default: begin
               r_state    <= IDLE;
               r_busy     <= 1'b0;
               r_inReady  <= 1'b0;
               r_outValid <= 1'b0;
            end
         endcase
      end
   end

   otf_qqm_reg #(
      .RADIX_BITS (RADIX_BITS),
      .W          (W)
   ) u_qqmReg (
      .clk   (clk),
      .reset (reset),
      .clear (w_start),
      .load  (w_accept),
      .digit (w_loadDigit),
      .q     (w_q)
   );

   assign bus.busy      = r_busy;
   assign bus.in_ready  = r_inReady;
   assign bus.out_valid = r_outValid;
   assign bus.out_value = w_q;

endmodule
